llc_pend_sched: RTL and testbench

- Pending-bitmap scheduler for the LLC.
- Accumulates requests for up to WIDTH indices (ways or pending-request slots) in a sticky bitmap.
- Issues them one at a time, lowest index first, through a registered valid/ready output slot. The selection is made by a priority encoder over the bitmap.
- Sits between the LLC request-tracking logic (upstream setters) and the way/slot service stage (downstream consumer).

---
 rtl/llc_pend_sched_pkg.sv | 9 +
 rtl/llc_pend_sched_pri_enc.sv | 27 ++
 rtl/llc_pend_sched.sv | 111 +++++++++++
 tb/tb_llc_pend_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/llc_pend_sched_pkg.sv
// Shared LLC scheduling package: default way/slot counts and the index type.
package llc_pend_sched_pkg;

  localparam int LLC_WIDTH     = 16;
  localparam int LLC_LOG_WIDTH = 4;

  typedef logic [LLC_LOG_WIDTH-1:0] idx_t;

endpackage

// File: rtl/llc_pend_sched_pri_enc.sv
// Lowest-index priority encoder over a request bitmap.
module pri_enc
  import llc_pend_sched_pkg::*;
#(
  parameter int WIDTH     = LLC_WIDTH,
  parameter int LOG_WIDTH = LLC_LOG_WIDTH
) (
  input  logic [WIDTH-1:0]     pend_i,
  output logic [LOG_WIDTH-1:0] enc_idx_o,
  output logic                 enc_valid_o
);

  // Scan upward; the first set bit found is latched and later bits are ignored.
  always_comb begin
    enc_idx_o   = {LOG_WIDTH{1'b0}};
    enc_valid_o = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (pend_i[i] && !enc_valid_o) begin
        enc_idx_o   = LOG_WIDTH'(i);
        enc_valid_o = 1'b1;
      end else begin
        enc_idx_o   = enc_idx_o;
      end
    end
  end

endmodule

// File: rtl/llc_pend_sched.sv
// Pending-bitmap scheduler: sticky request bitmap issued lowest index first
// through a registered valid/ready slot.
module llc_pend_sched
  import llc_pend_sched_pkg::*;
#(
  parameter int WIDTH     = LLC_WIDTH,
  parameter int LOG_WIDTH = LLC_LOG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 set_en,
  input  logic [LOG_WIDTH-1:0] set_idx,
  output logic                 out_valid,
  output logic [LOG_WIDTH-1:0] out_idx,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     pend_vec,
  output logic [LOG_WIDTH:0]   pend_cnt,
  output logic                 empty
);

  function automatic logic [WIDTH-1:0] onehot(input logic [LOG_WIDTH-1:0] idx);
    logic [WIDTH-1:0] v;
    v      = {WIDTH{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [LOG_WIDTH:0] popcount(input logic [WIDTH-1:0] v);
    logic [LOG_WIDTH:0] c;
    c = {(LOG_WIDTH+1){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{LOG_WIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [WIDTH-1:0]     pend_q, pend_d;
  logic [LOG_WIDTH:0]   cnt_q, cnt_d;
  logic                 valid_q, valid_d;
  logic [LOG_WIDTH-1:0] idx_q, idx_d;
  logic [LOG_WIDTH-1:0] enc_idx_s;
  logic                 enc_valid_s;
  logic                 load_s;
  logic [WIDTH-1:0]     clr_s, set_s;

  pri_enc #(
    .WIDTH     (WIDTH),
    .LOG_WIDTH (LOG_WIDTH)
  ) u_pri_enc (
    .pend_i      (pend_q),
    .enc_idx_o   (enc_idx_s),
    .enc_valid_o (enc_valid_s)
  );

  assign load_s = (!valid_q || out_ready) && enc_valid_s;

  // Next state: set is OR'd after the clear so a same-index set re-arms it.
  always_comb begin
    clr_s   = {WIDTH{1'b0}};
    set_s   = {WIDTH{1'b0}};
    valid_d = valid_q;
    idx_d   = idx_q;
    if (load_s) begin
      clr_s = onehot(enc_idx_s);
    end else begin
      clr_s = {WIDTH{1'b0}};
    end
    if (set_en) begin
      set_s = onehot(set_idx);
    end else begin
      set_s = {WIDTH{1'b0}};
    end
    pend_d = (pend_q & ~clr_s) | set_s;
    if (flush) begin
      pend_d  = {WIDTH{1'b0}};
      valid_d = 1'b0;
      idx_d   = {LOG_WIDTH{1'b0}};
    end else if (load_s) begin
      valid_d = 1'b1;
      idx_d   = enc_idx_s;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
    cnt_d = popcount(pend_d);
  end

  // State registers; reset discards any stalled slot contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= {WIDTH{1'b0}};
      cnt_q   <= {(LOG_WIDTH+1){1'b0}};
      valid_q <= 1'b0;
      idx_q   <= {LOG_WIDTH{1'b0}};
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign pend_vec  = pend_q;
  assign pend_cnt  = cnt_q;
  assign empty     = (pend_q == {WIDTH{1'b0}}) && !valid_q;

endmodule

// File: tb/tb_llc_pend_sched.sv
// Directed self-checking bench for llc_pend_sched (WIDTH=16).
module tb_llc_pend_sched;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        set_en;
  logic [3:0]  set_idx;
  logic        out_valid;
  logic [3:0]  out_idx;
  logic        out_ready;
  logic [15:0] pend_vec;
  logic [4:0]  pend_cnt;
  logic        empty;

  int          n_cmp;
  int          n_bad;
  logic [26:0] exp_s;
  logic [26:0] snap;

  llc_pend_sched #(.WIDTH(16), .LOG_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .set_en    (set_en),
    .set_idx   (set_idx),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .out_ready (out_ready),
    .pend_vec  (pend_vec),
    .pend_cnt  (pend_cnt),
    .empty     (empty)
  );

  // out_idx is only meaningful while out_valid is high
  assign snap = {out_valid, (out_valid ? out_idx : 4'd0), pend_vec, pend_cnt, empty};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; set_en = 1'b0; set_idx = 4'd0; out_ready = 1'b0;
    #3;
    exp_s = {1'b0, 4'd0, 16'h0000, 5'd0, 1'b1};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL reset_state: got %h want %h", snap, exp_s); end
    n_cmp++; if (out_idx !== 4'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", out_idx); end
    #4 rst = 1'b1;
    tick();
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL reset_idle: got %h want %h", snap, exp_s); end
  endtask

  task automatic test_single();
    out_ready = 1'b1; set_en = 1'b1; set_idx = 4'd5;
    tick();
    set_en = 1'b0;
    exp_s = {1'b0, 4'd0, 16'h0020, 5'd1, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL single_pend: got %h want %h", snap, exp_s); end
    tick();
    exp_s = {1'b1, 4'd5, 16'h0000, 5'd0, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL single_issue: got %h want %h", snap, exp_s); end
    tick();
    exp_s = {1'b0, 4'd0, 16'h0000, 5'd0, 1'b1};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL single_drain: got %h want %h", snap, exp_s); end
  endtask

  task automatic test_order_stall();
    out_ready = 1'b0;
    set_en = 1'b1; set_idx = 4'd9;
    tick();
    set_idx = 4'd3;
    tick();
    set_idx = 4'd12;
    tick();
    set_en = 1'b0;
    // 9 reaches the empty slot first; 3 and 12 wait behind it
    exp_s = {1'b1, 4'd9, 16'h1008, 5'd2, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL stall_start: got %h want %h", snap, exp_s); end
    tick(); tick(); tick();
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL stall_hold: got %h want %h", snap, exp_s); end
    out_ready = 1'b1;
    tick();
    exp_s = {1'b1, 4'd3, 16'h1000, 5'd1, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL b2b_first: got %h want %h", snap, exp_s); end
    tick();
    exp_s = {1'b1, 4'd12, 16'h0000, 5'd0, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL b2b_second: got %h want %h", snap, exp_s); end
    tick();
    exp_s = {1'b0, 4'd0, 16'h0000, 5'd0, 1'b1};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL b2b_drain: got %h want %h", snap, exp_s); end
  endtask

  task automatic test_rearm();
    out_ready = 1'b0;
    set_en = 1'b1; set_idx = 4'd3;
    tick();
    set_en = 1'b0;
    tick();
    set_en = 1'b1; set_idx = 4'd3;
    tick();
    set_en = 1'b0;
    exp_s = {1'b1, 4'd3, 16'h0008, 5'd1, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL rearm_pend: got %h want %h", snap, exp_s); end
    out_ready = 1'b1;
    tick();
    exp_s = {1'b1, 4'd3, 16'h0000, 5'd0, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL rearm_reissue: got %h want %h", snap, exp_s); end
    tick();
    exp_s = {1'b0, 4'd0, 16'h0000, 5'd0, 1'b1};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL rearm_drain: got %h want %h", snap, exp_s); end
  endtask

  task automatic test_full();
    logic [15:0] full_v;
    logic [15:0] ep;
    full_v = 16'hFFFF;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_en = 1'b1; set_idx = 4'(i);
      tick();
    end
    exp_s = {1'b1, 4'd0, 16'hFFFE, 5'd15, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL full_load: got %h want %h", snap, exp_s); end
    set_idx = 4'd1;
    tick();
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL full_dup: got %h want %h", snap, exp_s); end
    set_idx = 4'd0;
    tick();
    exp_s = {1'b1, 4'd0, 16'hFFFF, 5'd16, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL full_all_ones: got %h want %h", snap, exp_s); end
    set_idx = 4'd7;
    tick();
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL full_overflow: got %h want %h", snap, exp_s); end
    set_en = 1'b0; out_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      tick();
      ep = full_v << (j + 1);
      exp_s = {1'b1, 4'(j), ep, 5'(15 - j), 1'b0};
      n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL full_issue_%0d: got %h want %h", j, snap, exp_s); end
    end
    tick();
    exp_s = {1'b0, 4'd0, 16'h0000, 5'd0, 1'b1};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL full_drain: got %h want %h", snap, exp_s); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    for (int i = 7; i < 12; i++) begin
      set_en = 1'b1; set_idx = 4'(i);
      tick();
    end
    set_en = 1'b0;
    exp_s = {1'b1, 4'd7, 16'h0F00, 5'd4, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL flush_setup: got %h want %h", snap, exp_s); end
    flush = 1'b1; set_en = 1'b1; set_idx = 4'd2; out_ready = 1'b1;
    tick();
    flush = 1'b0; set_en = 1'b0;
    exp_s = {1'b0, 4'd0, 16'h0000, 5'd0, 1'b1};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL flush_clear: got %h want %h", snap, exp_s); end
    tick();
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL flush_set_dropped: got %h want %h", snap, exp_s); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_en = 1'b1; set_idx = 4'd4;
    tick();
    set_en = 1'b0;
    tick();
    exp_s = {1'b1, 4'd4, 16'h0000, 5'd0, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL areset_setup: got %h want %h", snap, exp_s); end
    #3 rst = 1'b0;
    #1;
    exp_s = {1'b0, 4'd0, 16'h0000, 5'd0, 1'b1};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL areset_immediate: got %h want %h", snap, exp_s); end
    #1 rst = 1'b1;
    out_ready = 1'b1;
    tick(); tick(); tick();
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL areset_no_replay: got %h want %h", snap, exp_s); end
    set_en = 1'b1; set_idx = 4'd6;
    tick();
    set_en = 1'b0;
    tick();
    exp_s = {1'b1, 4'd6, 16'h0000, 5'd0, 1'b0};
    n_cmp++; if (snap !== exp_s) begin n_bad++; $display("FAIL areset_new_issue: got %h want %h", snap, exp_s); end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_single();
    test_order_stall();
    test_rearm();
    test_full();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
